// File: rtl/instr_fetch_sequencer.sv
// Control unit: owns PC/IR, fetches from combinational code memory and sequences dmem/ALU handshakes.
// Optional build macro FETCH_WATCHDOG_EN adds an 8-bit MEM/ALU wait watchdog driving timeout.
module instr_fetch_sequencer #(
    parameter int unsigned Instruction_WIDTH       = 16,
    parameter int unsigned Instruction_Memory_Size = 16,
    parameter int unsigned Instruction_ADDR_WIDTH  = 4,
    parameter int unsigned opcode_SIZE             = 4,
    parameter int unsigned Operand_WIDTH           = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    output logic [Instruction_ADDR_WIDTH-1:0] addr,
    input  logic [Instruction_WIDTH-1:0]      instruction_read,
    output logic                              dmem_req,
    output logic                              dmem_we,
    output logic [Operand_WIDTH-1:0]          dmem_addr,
    input  logic                              dmem_ack,
    output logic                              load_a,
    output logic                              load_b,
    output logic                              store_c,
    output logic                              alu_start,
    output logic [opcode_SIZE-1:0]            alu_op,
    input  logic                              alu_done,
    output logic                              busy,
    output logic                              halted,
    output logic                              illegal,
    output logic                              timeout
);

    localparam logic [opcode_SIZE-1:0] OpNop  = opcode_SIZE'(0);
    localparam logic [opcode_SIZE-1:0] OpLda  = opcode_SIZE'(1);
    localparam logic [opcode_SIZE-1:0] OpLdb  = opcode_SIZE'(2);
    localparam logic [opcode_SIZE-1:0] OpStc  = opcode_SIZE'(3);
    localparam logic [opcode_SIZE-1:0] OpDiv  = opcode_SIZE'(7);
    localparam logic [opcode_SIZE-1:0] OpHalt = opcode_SIZE'(8);
    localparam logic [Instruction_ADDR_WIDTH-1:0] PcLast =
        Instruction_ADDR_WIDTH'(Instruction_Memory_Size - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StMem,
        StAlu,
        StHalted
    } state_e;

    state_e                            state_q, state_d;
    logic [Instruction_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [Instruction_WIDTH-1:0]      ir_q;
    logic [opcode_SIZE-1:0]            opcode;
    logic [Operand_WIDTH-1:0]          operand;
    logic                              start_ok;
    logic                              set_illegal;
    logic                              wd_expire;
    logic                              unused_ir_bits;

    assign opcode         = ir_q[Instruction_WIDTH-1 -: opcode_SIZE];
    assign operand        = ir_q[Operand_WIDTH-1:0];
    assign unused_ir_bits = ^ir_q[Instruction_WIDTH-opcode_SIZE-1:Operand_WIDTH];
    assign start_ok       = start && ((state_q == StIdle) || (state_q == StHalted));
    assign addr           = pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (state_q == StFetch) begin
                ir_q <= instruction_read;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        set_illegal = 1'b0;
        case (state_q)
            StIdle, StHalted: begin
                if (start) begin
                    state_d = StFetch;
                    pc_d    = '0;
                end
            end
            StFetch: state_d = StDecode;
            StDecode: begin
                pc_d = (pc_q == PcLast) ? '0 : pc_q + Instruction_ADDR_WIDTH'(1);
                if (opcode == OpNop) begin
                    state_d = StFetch;
                end else if (opcode <= OpStc) begin
                    state_d = StMem;
                end else if (opcode <= OpDiv) begin
                    state_d = StAlu;
                end else begin
                    state_d     = StHalted;
                    set_illegal = (opcode != OpHalt);
                end
            end
            // Completion wins over a watchdog expiry landing in the same cycle.
            StMem: begin
                if (dmem_ack) begin
                    state_d = StFetch;
                end else if (wd_expire) begin
                    state_d = StHalted;
                end
            end
            StAlu: begin
                if (alu_done) begin
                    state_d = StFetch;
                end else if (wd_expire) begin
                    state_d = StHalted;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            dmem_addr <= '0;
            load_a    <= 1'b0;
            load_b    <= 1'b0;
            store_c   <= 1'b0;
            alu_start <= 1'b0;
            alu_op    <= '0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            dmem_req  <= (state_d == StMem);
            dmem_we   <= (state_d == StMem) && (opcode == OpStc);
            dmem_addr <= (state_d == StMem) ? operand : '0;
            load_a    <= (state_q == StMem) && dmem_ack && (opcode == OpLda);
            load_b    <= (state_q == StMem) && dmem_ack && (opcode == OpLdb);
            store_c   <= (state_q == StMem) && dmem_ack && (opcode == OpStc);
            alu_start <= (state_q == StDecode) && (state_d == StAlu);
            alu_op    <= (state_d == StAlu) ? opcode : '0;
            busy      <= (state_d != StIdle) && (state_d != StHalted);
            halted    <= (state_d == StHalted);
            if (start_ok) begin
                illegal <= 1'b0;
            end else if (set_illegal) begin
                illegal <= 1'b1;
            end
        end
    end

`ifdef FETCH_WATCHDOG_EN
    logic [7:0] wd_cnt_q;
    logic       timeout_q;

    // Counter restarts on every state change, so it measures time spent in the current wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if ((state_d != state_q) || ((state_q != StMem) && (state_q != StAlu))) begin
                wd_cnt_q <= '0;
            end else begin
                wd_cnt_q <= wd_cnt_q + 8'd1;
            end
            if (start_ok) begin
                timeout_q <= 1'b0;
            end else if (wd_expire && (state_d == StHalted)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign wd_expire = ((state_q == StMem) || (state_q == StAlu)) && (wd_cnt_q == 8'd254);
    assign timeout   = timeout_q;
`else
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Self-checking bench for instr_fetch_sequencer: directed test-plan programs plus random
// programs checked against an instruction-level timing/event model.
module tb_instr_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  addr;
    logic [15:0] instruction_read;
    logic        dmem_req;
    logic        dmem_we;
    logic [7:0]  dmem_addr;
    logic        dmem_ack;
    logic        load_a;
    logic        load_b;
    logic        store_c;
    logic        alu_start;
    logic [3:0]  alu_op;
    logic        alu_done;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic        timeout;

    logic [15:0] prog [16];
    int          checks   = 0;
    int          failures = 0;
    int          obs_ev[$];
    int          exp_ev[$];
    int          obs_cyc;
    int          obs_perr;
    int          exp_cyc;
    int          exp_pc;
    bit          exp_illegal;

    instr_fetch_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .addr             (addr),
        .instruction_read (instruction_read),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_ack         (dmem_ack),
        .load_a           (load_a),
        .load_b           (load_b),
        .store_c          (store_c),
        .alu_start        (alu_start),
        .alu_op           (alu_op),
        .alu_done         (alu_done),
        .busy             (busy),
        .halted           (halted),
        .illegal          (illegal),
        .timeout          (timeout)
    );

    assign instruction_read = prog[addr];
    always #5 clk = ~clk;

    // Event codes: 0x1WAA memory access (W=write), 0x200N register strobe, 0x30OP ALU launch.
    function automatic void model_run(input int ack_wait, input int done_wait);
        int pc;
        int op;
        int opd;
        bit done;
        pc = 0;
        done = 0;
        exp_ev.delete();
        exp_cyc = 0;
        exp_illegal = 0;
        for (int n = 0; n < 64 && !done; n++) begin
            op  = int'(prog[pc][15:12]);
            opd = int'(prog[pc][7:0]);
            pc  = (pc + 1) % 16;
            if (op == 0) begin
                exp_cyc += 2;
            end else if (op <= 3) begin
                exp_cyc += 3 + ack_wait;
                exp_ev.push_back(32'h1000 | ((op == 3) ? 32'h100 : 32'h0) | opd);
                exp_ev.push_back(32'h2000 | op);
            end else if (op <= 7) begin
                exp_cyc += 3 + done_wait;
                exp_ev.push_back(32'h3000 | op);
            end else begin
                exp_cyc += 2;
                exp_illegal = (op != 8);
                done = 1;
            end
        end
        exp_pc = pc;
    endfunction

    function automatic int first_diff();
        int n;
        n = (obs_ev.size() > exp_ev.size()) ? obs_ev.size() : exp_ev.size();
        for (int i = 0; i < n; i++) begin
            if (i >= obs_ev.size() || i >= exp_ev.size()) return i;
            if (obs_ev[i] != exp_ev[i]) return i;
        end
        return -1;
    endfunction

    function automatic int ev_at(input bit from_obs, input int i);
        if (from_obs) return (i < obs_ev.size()) ? obs_ev[i] : -1;
        return (i < exp_ev.size()) ? exp_ev[i] : -1;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        start = 1'b0;
        dmem_ack = 1'b0;
        alu_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Starts the loaded program and plays memory/ALU responder until halted or limit cycles.
    task automatic drive_run(input int ack_wait, input int done_wait, input bit poke,
                             input int limit);
        int mem_cnt = 0, alu_cnt = 0, alu_cur = 0, last_addr = 0, n_strobe;
        bit in_alu = 0, prev_req = 0, last_we = 0;
        obs_ev.delete();
        obs_cyc  = 0;
        obs_perr = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int it = 0; it < limit && halted !== 1'b1; it++) begin
            if (busy === 1'b1) obs_cyc++;
            if (dmem_req === 1'b1) begin
                if (!prev_req) begin
                    obs_ev.push_back(32'h1000 | (dmem_we ? 32'h100 : 32'h0) | int'(dmem_addr));
                    last_addr = int'(dmem_addr);
                    last_we   = dmem_we;
                    mem_cnt   = 0;
                end else if (int'(dmem_addr) != last_addr || dmem_we != last_we) begin
                    obs_perr++;
                end
                dmem_ack = (mem_cnt == ack_wait);
                mem_cnt++;
            end else begin
                dmem_ack = ($urandom_range(0, 1) == 1);
            end
            n_strobe = int'(load_a) + int'(load_b) + int'(store_c);
            if (n_strobe > 1 || (n_strobe == 1 && (dmem_req || !prev_req))) obs_perr++;
            if (load_a)  obs_ev.push_back(32'h2001);
            if (load_b)  obs_ev.push_back(32'h2002);
            if (store_c) obs_ev.push_back(32'h2003);
            if (alu_start) begin
                if (in_alu) obs_perr++;
                obs_ev.push_back(32'h3000 | int'(alu_op));
                in_alu  = 1;
                alu_cnt = 0;
                alu_cur = int'(alu_op);
            end
            if (in_alu) begin
                if (int'(alu_op) != alu_cur || dmem_req) obs_perr++;
                alu_done = (alu_cnt == done_wait);
                if (alu_done) in_alu = 0;
                alu_cnt++;
            end else begin
                alu_done = ($urandom_range(0, 1) == 1);
            end
            start = poke && busy && ($urandom_range(0, 3) == 0);
            prev_req = dmem_req;
            @(negedge clk);
        end
        start = 1'b0;
        dmem_ack = 1'b0;
        alu_done = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({addr, dmem_req, dmem_we, dmem_addr, load_a, load_b, store_c, alu_start, alu_op,
             busy, halted, illegal, timeout} !== '0) begin
            failures++;
            $display("FAIL reset_outputs addr=%h req=%b addr_d=%h busy=%b halted=%b required all 0",
                     addr, dmem_req, dmem_addr, busy, halted);
        end
        checks++;
        if (dut.pc_q !== 4'd0) begin
            failures++;
            $display("FAIL reset_pc got %0d required 0", dut.pc_q);
        end
    endtask

    task automatic load_basic(input logic [3:0] alu_opcode);
        foreach (prog[i]) prog[i] = 16'h8000;
        prog[0] = 16'h1009;
        prog[1] = 16'h200A;
        prog[2] = {alu_opcode, 12'h000};
        prog[3] = 16'h3001;
        prog[4] = 16'h8000;
    endtask

    task automatic test_program();
        int d;
        load_basic(4'd4);
        exp_ev = '{32'h1009, 32'h2001, 32'h100A, 32'h2002, 32'h3004, 32'h1101, 32'h2003};
        drive_run(1, 1, 0, 200);
        checks++;
        if (halted !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL prog_halt halted=%b busy=%b required 1/0", halted, busy);
        end
        checks++;
        if (obs_cyc != 18) begin
            failures++;
            $display("FAIL prog_cycles got %0d required 18", obs_cyc);
        end
        d = first_diff();
        checks++;
        if (d != -1) begin
            failures++;
            $display("FAIL prog_events idx %0d got %h required %h", d, ev_at(1, d), ev_at(0, d));
        end
        checks++;
        if (dut.pc_q !== 4'd5 || illegal !== 1'b0 || obs_perr != 0) begin
            failures++;
            $display("FAIL prog_final pc=%0d illegal=%b perr=%0d required 5/0/0",
                     dut.pc_q, illegal, obs_perr);
        end
    endtask

    task automatic test_div_slow();
        int d;
        load_basic(4'd7);
        model_run(1, 10);
        drive_run(1, 10, 0, 300);
        checks++;
        if (halted !== 1'b1 || obs_cyc != exp_cyc) begin
            failures++;
            $display("FAIL div_cycles halted=%b got %0d required %0d", halted, obs_cyc, exp_cyc);
        end
        d = first_diff();
        checks++;
        if (d != -1 || obs_perr != 0) begin
            failures++;
            $display("FAIL div_events idx %0d got %h required %h perr=%0d",
                     d, ev_at(1, d), ev_at(0, d), obs_perr);
        end
    endtask

    task automatic test_nop_wrap();
        foreach (prog[i]) prog[i] = {4'h0, 12'($urandom)};
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (busy !== 1'b1 || halted !== 1'b0) begin
                failures++;
                $display("FAIL nop_busy cycle %0d busy=%b halted=%b required 1/0", k, busy, halted);
            end
            if (k % 2 == 0) begin
                checks++;
                if (addr !== 4'((k / 2) % 16)) begin
                    failures++;
                    $display("FAIL nop_addr cycle %0d got %0d required %0d", k, addr, (k / 2) % 16);
                end
            end
            @(negedge clk);
        end
        apply_reset();
    endtask

    task automatic test_illegal();
        int n;
        foreach (prog[i]) prog[i] = 16'($urandom);
        prog[0] = {4'hC, 12'($urandom)};
        drive_run(0, 0, 0, 50);
        checks++;
        if (obs_cyc != 2 || halted !== 1'b1 || illegal !== 1'b1) begin
            failures++;
            $display("FAIL illegal_halt cycles=%0d halted=%b illegal=%b required 2/1/1",
                     obs_cyc, halted, illegal);
        end
        prog[0] = 16'h8000;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (illegal !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL illegal_clear illegal=%b busy=%b required 0/1", illegal, busy);
        end
        n = 0;
        while (halted !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (halted !== 1'b1 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL illegal_rerun halted=%b illegal=%b required 1/0", halted, illegal);
        end
    endtask

    task automatic test_reset_mid_mem();
        int n;
        int d;
        foreach (prog[i]) prog[i] = 16'h8000;
        prog[0] = 16'h1009;
        dmem_ack = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (dmem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dmem_req !== 1'b1 || dmem_addr !== 8'd9) begin
            failures++;
            $display("FAIL midrst_req req=%b addr=%h required 1/09", dmem_req, dmem_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dmem_req, dmem_addr, load_a, busy, halted} !== '0) begin
            failures++;
            $display("FAIL midrst_drop req=%b addr=%h busy=%b required 0", dmem_req, dmem_addr, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (dut.pc_q !== 4'd0 || busy !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL midrst_idle pc=%0d busy=%b halted=%b required 0/0/0",
                     dut.pc_q, busy, halted);
        end
        exp_ev = '{32'h1009, 32'h2001};
        drive_run(0, 0, 0, 50);
        d = first_diff();
        checks++;
        if (d != -1 || obs_cyc != 5 || halted !== 1'b1) begin
            failures++;
            $display("FAIL midrst_rerun idx %0d got %h required %h cycles=%0d required 5",
                     d, ev_at(1, d), ev_at(0, d), obs_cyc);
        end
    endtask

    task automatic test_random();
        int len, aw, dw, d;
        for (int t = 0; t < 30; t++) begin
            foreach (prog[i]) prog[i] = 16'($urandom);
            len = $urandom_range(0, 12);
            for (int i = 0; i < len; i++) prog[i] = {4'($urandom_range(0, 7)), 12'($urandom)};
            prog[len] = {($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'd8,
                         12'($urandom)};
            aw = $urandom_range(0, 4);
            dw = $urandom_range(0, 4);
            model_run(aw, dw);
            drive_run(aw, dw, 1, 600);
            checks++;
            if (halted !== 1'b1 || obs_cyc != exp_cyc) begin
                failures++;
                $display("FAIL rand%0d_cycles halted=%b got %0d required %0d",
                         t, halted, obs_cyc, exp_cyc);
            end
            d = first_diff();
            checks++;
            if (d != -1) begin
                failures++;
                $display("FAIL rand%0d_events idx %0d got %h required %h",
                         t, d, ev_at(1, d), ev_at(0, d));
            end
            checks++;
            if (int'(dut.pc_q) != exp_pc || illegal !== exp_illegal || obs_perr != 0) begin
                failures++;
                $display("FAIL rand%0d_final pc=%0d illegal=%b perr=%0d required %0d/%b/0",
                         t, dut.pc_q, illegal, obs_perr, exp_pc, exp_illegal);
            end
        end
    endtask

    task automatic test_no_ack();
        foreach (prog[i]) prog[i] = 16'h8000;
        prog[0] = 16'h1005;
        drive_run(-1, 0, 0, 1000);
`ifdef FETCH_WATCHDOG_EN
        checks++;
        if (halted !== 1'b1 || timeout !== 1'b1 || dmem_req !== 1'b0 || obs_cyc != 257) begin
            failures++;
            $display("FAIL wd_timeout halted=%b timeout=%b req=%b cycles=%0d required 1/1/0/257",
                     halted, timeout, dmem_req, obs_cyc);
        end
`else
        checks++;
        if (busy !== 1'b1 || dmem_req !== 1'b1 || halted !== 1'b0 || timeout !== 1'b0 ||
            obs_cyc != 1000) begin
            failures++;
            $display("FAIL noack_wait busy=%b req=%b halted=%b timeout=%b cycles=%0d required 1/1/0/0/1000",
                     busy, dmem_req, halted, timeout, obs_cyc);
        end
`endif
        apply_reset();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        dmem_ack = 1'b0;
        alu_done = 1'b0;
        foreach (prog[i]) prog[i] = 16'h0;
        test_reset();
        test_program();
        test_div_slow();
        test_nop_wrap();
        test_illegal();
        test_reset_mid_mem();
        test_random();
        test_no_ack();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
